// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of every bus-level signal around mem_arbiter: the Ibex instruction
// port (req/gnt/rvalid), the Ibex data port (req/gnt/rvalid) and the shared
// downstream valid/ready memory port, plus the abort pulse.
//   slave  : the arbiter's view (accepts CPU requests, drives the memory bus)
//   master : the environment's view (CPU ports and memory slave)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // instruction port
  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;
  logic              instr_err_o;
  // data port
  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [31:0]       data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;
  // downstream memory port
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  // abort pulse
  logic              timeout_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_ready, mem_rdata,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output timeout_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_ready, mem_rdata,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one valid/ready memory bus between the Ibex instruction-fetch and
// data ports. One access is in flight at a time; a per-access timeout turns a
// hung slave into an error response.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : mem_arbiter_if.slave (CPU instr/data ports, memory port, timeout_o)
// Parameters:
//   ADDR_W         : address width (must match the interface instance)
//   TIMEOUT_CYCLES : cycles mem_valid may wait for mem_ready (>= 2)
// Build option:
//   MEM_ARBITER_RR_EN : round-robin arbitration between the two ports;
//                       undefined -> fixed data-over-instruction priority.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            r_state, w_next;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_we;
  logic              r_own_d;     // 1: data port owns the access
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_rv_i, r_rv_d;
  logic              r_timeout;
`ifdef MEM_ARBITER_RR_EN
  logic              r_last_i;    // 1: instruction port was served last
`endif

  logic w_can_gnt, w_pick_d, w_gnt_d, w_gnt_i, w_grant, w_done, w_abort;

  always_comb begin
    // reset gates the grant so gnt never shows while the arbiter is held
    w_can_gnt = (r_state != ACCESS) && !reset;
`ifdef MEM_ARBITER_RR_EN
    w_pick_d  = bus.data_req_i && (!bus.instr_req_i || r_last_i);
`else
    w_pick_d  = bus.data_req_i;
`endif
    w_gnt_d   = w_can_gnt && w_pick_d;
    w_gnt_i   = w_can_gnt && bus.instr_req_i && !w_pick_d;
    w_grant   = w_gnt_d || w_gnt_i;
    w_done    = (r_state == ACCESS) && bus.mem_ready;
    // ready in the final allowed cycle still counts as a completion
    w_abort   = (r_state == ACCESS) && !bus.mem_ready && (r_cnt == CNT_MAX);
    w_next    = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_next = RESP;
      RESP:    w_next = w_grant ? ACCESS : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_we        <= 1'b0;
      r_own_d     <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rv_i      <= 1'b0;
      r_rv_d      <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      r_last_i    <= 1'b1;
`endif
    end else begin
      r_mem_valid <= (w_next == ACCESS);
      r_rv_i      <= 1'b0;
      r_rv_d      <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_grant) begin
        r_cnt   <= '0;
        r_own_d <= w_gnt_d;
        r_we    <= w_gnt_d && bus.data_we_i;
        r_addr  <= w_gnt_d ? bus.data_addr_i : bus.instr_addr_i;
        r_wdata <= w_gnt_d ? bus.data_wdata_i : 32'h0;
        r_wstrb <= (w_gnt_d && bus.data_we_i) ? bus.data_be_i : 4'h0;
`ifdef MEM_ARBITER_RR_EN
        r_last_i <= w_gnt_i;
`endif
      end else if (r_state == ACCESS && !bus.mem_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done || w_abort) begin
        r_rdata   <= (w_done && !r_we) ? bus.mem_rdata : 32'h0;
        r_err     <= w_abort;
        r_timeout <= w_abort;
        r_rv_d    <= r_own_d;
        r_rv_i    <= !r_own_d;
      end
    end
  end

  assign bus.instr_gnt_o    = w_gnt_i;
  assign bus.data_gnt_o     = w_gnt_d;
  assign bus.instr_rvalid_o = r_rv_i;
  assign bus.data_rvalid_o  = r_rv_d;
  assign bus.instr_rdata_o  = r_rdata;
  assign bus.data_rdata_o   = r_rdata;
  assign bus.instr_err_o    = r_err;
  assign bus.data_err_o     = r_err;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_wdata      = r_wdata;
  assign bus.mem_wstrb      = r_wstrb;
  assign bus.timeout_o      = r_timeout;
endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (TIMEOUT_CYCLES = 8). A bench-owned slave
// answers after a programmable number of wait states. A transaction-timeline
// model predicts, per cycle, grants, the mem_valid window, responses and
// abort pulses; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int T = 8;

  logic clk, reset;
  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- bench-owned memory slave ----------------
  int          slave_wait  = 0;
  bit          slave_never = 0;
  bit          slave_fixed = 0;
  logic [31:0] slave_val   = 32'h0;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  assign bus.mem_rdata = slave_fixed ? slave_val : fdata(bus.mem_addr);

  initial begin
    int acc_cyc;
    bit prev_v;
    acc_cyc = 0;
    prev_v  = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_valid) acc_cyc = prev_v ? acc_cyc + 1 : 0;
      prev_v = bus.mem_valid;
      bus.mem_ready = bus.mem_valid && !slave_never && (acc_cyc == slave_wait);
    end
  end

  // ---------------- timeline model + per-cycle compare ----------------
  bit          m_busy = 0, m_own_d = 0, m_err = 0, m_last_i = 1;
  int          m_gcyc = 0, m_resp = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  string       g_log = "";

  always @(negedge clk) begin
    bit exp_rv, exp_mv, avail, eg_d, eg_i;
    int w;
    if (reset) begin
      chk("rst_mem_valid", bus.mem_valid, 0);
      chk("rst_gnt", {bus.data_gnt_o, bus.instr_gnt_o}, 0);
      chk("rst_rvalid", {bus.data_rvalid_o, bus.instr_rvalid_o}, 0);
      chk("rst_timeout", bus.timeout_o, 0);
      m_busy   = 0;
      m_last_i = 1;
    end else begin
      exp_rv = m_busy && (cyc == m_resp);
      exp_mv = m_busy && (cyc > m_gcyc) && (cyc < m_resp);
      chk("mem_valid", bus.mem_valid, exp_mv);
      if (exp_mv) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("mem_wstrb", bus.mem_wstrb, m_strb);
      end
      chk("instr_rvalid", bus.instr_rvalid_o, exp_rv && !m_own_d);
      chk("data_rvalid", bus.data_rvalid_o, exp_rv && m_own_d);
      chk("rvalid_excl", bus.instr_rvalid_o & bus.data_rvalid_o, 0);
      chk("timeout_o", bus.timeout_o, exp_rv && m_err);
      if (exp_rv) begin
        chk("rdata", m_own_d ? bus.data_rdata_o : bus.instr_rdata_o, m_rdata);
        chk("err", m_own_d ? bus.data_err_o : bus.instr_err_o, m_err);
        m_busy = 0;
      end
      avail = !m_busy;
`ifdef MEM_ARBITER_RR_EN
      eg_d = avail && bus.data_req_i && (!bus.instr_req_i || m_last_i);
`else
      eg_d = avail && bus.data_req_i;
`endif
      eg_i = avail && bus.instr_req_i && !eg_d;
      chk("data_gnt", bus.data_gnt_o, eg_d);
      chk("instr_gnt", bus.instr_gnt_o, eg_i);
      if (eg_d || eg_i) begin
        w        = slave_never ? 100000 : slave_wait;
        m_busy   = 1;
        m_own_d  = eg_d;
        m_gcyc   = cyc;
        m_err    = (w >= T);
        m_resp   = cyc + 1 + (m_err ? T : w + 1);
        m_addr   = eg_d ? bus.data_addr_i : bus.instr_addr_i;
        m_wdata  = eg_d ? bus.data_wdata_i : 32'h0;
        m_strb   = (eg_d && bus.data_we_i) ? bus.data_be_i : 4'h0;
        m_rdata  = (m_err || (eg_d && bus.data_we_i)) ? 32'h0 :
                   (slave_fixed ? slave_val : fdata(m_addr));
        m_last_i = eg_i;
        g_log    = {g_log, eg_d ? "D" : "I"};
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one request on an idle bus; returns at the first ACCESS cycle.
  task automatic issue(input bit d, input bit we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    step();
    if (d) begin
      bus.data_req_i = 1; bus.data_we_i = we; bus.data_be_i = be;
      bus.data_addr_i = a; bus.data_wdata_i = wd;
    end else begin
      bus.instr_req_i = 1; bus.instr_addr_i = a;
    end
    @(negedge clk);
    chk(d ? "lit_gnt_d" : "lit_gnt_i", d ? bus.data_gnt_o : bus.instr_gnt_o, 1);
    step();
    bus.data_req_i = 0; bus.instr_req_i = 0; bus.data_we_i = 0;
  endtask

  // Count mem_valid cycles; returns at the first negedge where it is low.
  task automatic count_valid(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.mem_valid) break;
      n++;
    end
  endtask

  initial begin
    int n, gi, gd;
    string exp_log;
    reset = 1;
    bus.instr_req_i = 0; bus.instr_addr_i = 0;
    bus.data_req_i = 1; bus.data_we_i = 0; bus.data_be_i = 0;
    bus.data_addr_i = 32'h2000_0000; bus.data_wdata_i = 0;

    // reset state, with a request held high
    repeat (2) @(negedge clk);
    chk("lit_rst_gnt", bus.data_gnt_o, 0);
    chk("lit_rst_addr", bus.mem_addr, 0);
    chk("lit_rst_wstrb", bus.mem_wstrb, 0);
    chk("lit_rst_wdata", bus.mem_wdata, 0);
    step();
    reset = 0; bus.data_req_i = 0;
    repeat (2) step();

    // zero-wait read
    slave_fixed = 1; slave_val = 32'hDEAD_BEEF; slave_wait = 0;
    issue(1, 0, 4'h0, 32'h2000_0010, 32'h0);
    @(negedge clk);
    chk("zw_mem_valid", bus.mem_valid, 1);
    chk("zw_mem_addr", bus.mem_addr, 32'h2000_0010);
    chk("zw_wstrb", bus.mem_wstrb, 0);
    @(negedge clk);
    chk("zw_rvalid", bus.data_rvalid_o, 1);
    chk("zw_rdata", bus.data_rdata_o, 32'hDEAD_BEEF);
    chk("zw_err", bus.data_err_o, 0);
    chk("zw_valid_drop", bus.mem_valid, 0);
    step();

    // write with 3 wait states
    slave_fixed = 0; slave_wait = 3;
    issue(1, 1, 4'b0011, 32'h2000_0020, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_valid", bus.mem_valid, 1);
      chk("wr_wstrb", bus.mem_wstrb, 4'b0011);
      chk("wr_wdata", bus.mem_wdata, 32'h1234_5678);
    end
    @(negedge clk);
    chk("wr_rvalid", bus.data_rvalid_o, 1);
    chk("wr_rdata", bus.data_rdata_o, 0);
    step();

    // ready on the last allowed cycle
    slave_fixed = 1; slave_val = 32'hCAFE_F00D; slave_wait = T - 1;
    issue(1, 0, 4'h0, 32'h2000_0030, 32'h0);
    count_valid(n);
    chk("last_valid_cycles", n, 8);
    chk("last_rvalid", bus.data_rvalid_o, 1);
    chk("last_err", bus.data_err_o, 0);
    chk("last_timeout", bus.timeout_o, 0);
    chk("last_rdata", bus.data_rdata_o, 32'hCAFE_F00D);
    step();

    // timeout on an instruction fetch
    slave_fixed = 0; slave_never = 1;
    issue(0, 0, 4'h0, 32'h0000_0100, 32'h0);
    count_valid(n);
    chk("to_valid_cycles", n, 8);
    chk("to_rvalid", bus.instr_rvalid_o, 1);
    chk("to_err", bus.instr_err_o, 1);
    chk("to_rdata", bus.instr_rdata_o, 0);
    chk("to_pulse", bus.timeout_o, 1);
    @(negedge clk);
    chk("to_pulse_end", bus.timeout_o, 0);
    slave_never = 0; slave_wait = 1;
    issue(0, 0, 4'h0, 32'h0000_0104, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("post_to_rvalid", bus.instr_rvalid_o, 1);
    chk("post_to_err", bus.instr_err_o, 0);
    chk("post_to_rdata", bus.instr_rdata_o, 32'h5B5E_5A5A);
    step();

    // contention: both ports request continuously for 4 accesses
    slave_wait = 0;
    g_log = "";
    step();
    bus.data_req_i = 1; bus.data_addr_i = 32'h2000_0100; bus.data_we_i = 0;
    bus.instr_req_i = 1; bus.instr_addr_i = 32'h0000_0200;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      gd = bus.data_gnt_o; gi = bus.instr_gnt_o;
      if (gd || gi) n++;
      step();
      if (n == 4) begin
        bus.data_req_i = 0; bus.instr_req_i = 0;
      end else begin
        if (gd) bus.data_addr_i = bus.data_addr_i + 4;
        if (gi) bus.instr_addr_i = bus.instr_addr_i + 4;
      end
    end
    bus.data_req_i = 0; bus.instr_req_i = 0;
    chk("cont_grants", n, 4);
    repeat (4) step();
`ifdef MEM_ARBITER_RR_EN
    exp_log = "DIDI";
`else
    exp_log = "DDDD";
`endif
    n_cmp++;
    if (g_log != exp_log) begin
      n_bad++;
      $display("FAIL cont_order: got %s expected %s", g_log, exp_log);
    end

    // reset in the middle of an access
    slave_wait = 5;
    issue(1, 0, 4'h0, 32'h2000_0040, 32'h0);
    step();
    step();
    #1 reset = 1;
    @(negedge clk);
    chk("rmid_valid", bus.mem_valid, 0);
    chk("rmid_addr", bus.mem_addr, 0);
    step();
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rmid_no_rvalid", {bus.data_rvalid_o, bus.instr_rvalid_o}, 0);
    end
    slave_wait = 0;
    issue(1, 0, 4'h0, 32'h2000_0040, 32'h0);
    @(negedge clk);
    chk("rfresh_valid", bus.mem_valid, 1);
    @(negedge clk);
    chk("rfresh_rvalid", bus.data_rvalid_o, 1);
    chk("rfresh_rdata", bus.data_rdata_o, 32'h5A1A_7A5A);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
